booth_mult_seq: RTL and testbench



---
 rtl/booth_mult_seq.sv | 145 ++++++++++++++
 tb/tb_booth_mult_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes and per-op signed/unsigned mode.
// Latency: ITERS cycles from acceptance to out_valid (13 at WIDTH=25), one shared adder.
// Backpressure: in_ready low while busy; out_z held stable in DONE until out_ready.
module booth_mult_seq #(
  parameter int WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_z,
  output logic                 busy
);

  localparam int ITERS = (WIDTH + 2) / 2;
  localparam int QW    = 2 * ITERS;       // multiplier register, padded to whole digit pairs
  localparam int AW    = WIDTH + 3;       // accumulator wide enough for +/-2Mx
  localparam int MW    = WIDTH + 1;       // extended multiplicand
  localparam int HW    = 2 * WIDTH - QW;  // product bits that live in the accumulator
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [QW-1:0]   q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [MW-1:0]   mx_q, mx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [AW-1:0]   mx1_w;
  logic [AW-1:0]   mx2_w;
  logic [AW-1:0]   addend_w;
  logic [AW-1:0]   sum_w;
  logic            m_ext_bit;
  logic            q_ext_bit;

  // Booth digit recode, single accumulate, and next-state / output decode
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    qm1_d       = qm1_q;
    mx_d        = mx_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    mx1_w = {{2{mx_q[MW-1]}}, mx_q};
    mx2_w = {mx_q[MW-1], mx_q, 1'b0};
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend_w = mx1_w;
      3'b011:         addend_w = mx2_w;
      3'b100:         addend_w = -mx2_w;
      3'b101, 3'b110: addend_w = -mx1_w;
      default:        addend_w = '0;
    endcase
    sum_w = a_q + addend_w;

    // Unsigned operands get a zero top bit so the signed Booth walk sees them as positive
    m_ext_bit = in_signed & in_m[WIDTH-1];
    q_ext_bit = in_signed & in_q[WIDTH-1];

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mx_d       = {m_ext_bit, in_m};
          q_d        = {{(QW-WIDTH){q_ext_bit}}, in_q};
          a_d        = '0;
          qm1_d      = 1'b0;
          cnt_d      = '0;
          state_d    = CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      CALC: begin
        // Arithmetic shift of {A,Q,q_-1} right by two after the add
        a_d   = {{2{sum_w[AW-1]}}, sum_w[AW-1:2]};
        q_d   = {sum_w[1:0], q_q[QW-1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      qm1_q       <= 1'b0;
      mx_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      qm1_q       <= qm1_d;
      mx_q        <= mx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_z     = {a_q[HW-1:0], q_q};

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=25: corner products, latency, backpressure, reset abort.
// Stimulus is driven 1ns after the rising edge; outputs are sampled at the same point.
// Every comparison is an immediate assertion that counts and reports failures.
module tb_booth_mult_seq;

  localparam int W     = 25;
  localparam int ITERS = 13;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_signed = 1'b0;
  logic [W-1:0]     in_m = '0;
  logic [W-1:0]     in_q = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic [2*W-1:0]   out_z;

  int n_cmp = 0;
  int n_bad = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_m      (in_m),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; hold<0 raises out_ready early (during CALC), hold>0 delays it
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] m,
                        input logic [W-1:0] q, input logic [2*W-1:0] exp, input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, " in_ready idle"}, 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    in_signed = s;
    in_m      = m;
    in_q      = q;
    tick();
    in_valid  = 1'b0;
    in_signed = ~s;
    in_m      = W'($urandom);
    in_q      = W'($urandom);
    check({tag, " busy"}, 64'(busy), 64'(1));
    if (hold < 0) out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(ITERS));
    for (int i = 0; i < hold; i++) tick();
    check({tag, " z"}, 64'(out_z), 64'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " in_ready after"}, 64'(in_ready), 64'(1));
    check({tag, " out_valid after"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    logic        rs;
    logic [W-1:0] rm, rq;
    longint      ma, qa, pr;
    logic [2*W-1:0] rexp;
    int          guard;
    int          spurious;

    // Reset state
    #12;
    check("rst in_ready", 64'(in_ready), 64'(1));
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst out_z", 64'(out_z), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Directed corner products
    run_op("s -1*-1",     1'b1, 25'h1FFFFFF, 25'h1FFFFFF, 50'h0000000000001, 0);
    run_op("u max*max",   1'b0, 25'h1FFFFFF, 25'h1FFFFFF, 50'h3FFFFFC000001, 0);
    run_op("s min*min",   1'b1, 25'h1000000, 25'h1000000, 50'h1000000000000, 0);
    run_op("s 3*-5",      1'b1, 25'h0000003, 25'h1FFFFFB, 50'h3FFFFFFFFFFF1, -1);
    run_op("s max*min",   1'b1, 25'h0FFFFFF, 25'h1000000, 50'h3000001000000, 2);
    run_op("u max*1",     1'b0, 25'h1FFFFFF, 25'h0000001, 50'h0000001FFFFFF, 0);
    run_op("s 0*-1",      1'b1, 25'h0000000, 25'h1FFFFFF, 50'h0000000000000, 0);
    run_op("u 2^24*2",    1'b0, 25'h1000000, 25'h0000002, 50'h0000002000000, 1);

    // Backpressure: product held, in_ready low, in_valid pulses ignored
    in_valid = 1'b1; in_signed = 1'b1; in_m = 25'h0FFFFFF; in_q = 25'h1000000;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      tick();
      guard++;
    end
    check("bp latency", 64'(guard), 64'(ITERS));
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      in_signed = 1'b0;
      in_m      = W'($urandom);
      in_q      = W'($urandom);
      tick();
      check("bp z stable", 64'(out_z), 64'(50'h3000001000000));
      check("bp in_ready", 64'(in_ready), 64'(0));
      check("bp out_valid", 64'(out_valid), 64'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp release in_ready", 64'(in_ready), 64'(1));
    check("bp release busy", 64'(busy), 64'(0));

    // Reset mid-CALC aborts the op; operands changed during CALC
    in_valid = 1'b1; in_signed = 1'b1; in_m = 25'd100; in_q = 25'd200;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_m = W'($urandom);
      in_q = W'($urandom);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort in_ready", 64'(in_ready), 64'(1));
    check("abort out_valid", 64'(out_valid), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    check("abort out_z", 64'(out_z), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) spurious++;
    end
    check("abort no out_valid", 64'(spurious), 64'(0));
    run_op("s 7*6", 1'b1, 25'd7, 25'd6, 50'd42, 0);

    // Mixed-mode ops against a 64-bit reference multiply
    for (int k = 0; k < 30; k++) begin
      rs = 1'(k % 2);
      rm = W'($urandom);
      rq = W'($urandom);
      if (k == 0) rm = 25'h1000000;
      if (k == 1) rq = 25'h1FFFFFF;
      if (rs) begin
        ma = longint'($signed(rm));
        qa = longint'($signed(rq));
      end else begin
        ma = longint'(rm);
        qa = longint'(rq);
      end
      pr   = ma * qa;
      rexp = pr[2*W-1:0];
      run_op(rs ? "rand signed" : "rand unsigned", rs, rm, rq, rexp, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
